// File: rtl/watchdog_ctrl.sv
// watchdog_ctrl: frame-tick watchdog with a fixed-length reset pulse.
//   CK        : clock; all state changes on the rising edge
//   RESET     : asynchronous active-high reset
//   CE        : count-enable tick, one CK cycle wide
//   KICK      : kick level (already registered upstream); rising edge restarts count
//   DISABLE   : inhibit; holds the counter at zero while counting
//   WD_RESET  : registered active-high reset request, PULSE_LEN cycles per timeout
//   WD_CNT    : current timeout counter value
//   FIRE_CNT  : saturating number of timeouts since RESET
module watchdog_ctrl #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PULSE_LEN = 8
) (
  input  logic                 CK,
  input  logic                 RESET,
  input  logic                 CE,
  input  logic                 KICK,
  input  logic                 DISABLE,
  output logic                 WD_RESET,
  output logic [CNT_WIDTH-1:0] WD_CNT,
  output logic [3:0]           FIRE_CNT
);

  typedef enum logic {
    COUNT = 1'b0,
    FIRE  = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [7:0]           PULSE_LAST = 8'(PULSE_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           fire_cnt_q, fire_cnt_d;
  logic                 wd_reset_q, wd_reset_d;
  logic                 kick_d_q;
  logic [7:0]           pulse_q, pulse_d;

  logic kick_ev;
  logic terminal;
  logic timeout;
  logic pulse_done;

  assign kick_ev    = KICK & ~kick_d_q;
  assign terminal   = (cnt_q == '1);
  // Kick and DISABLE both outrank the terminal-count tick.
  assign timeout    = (state_q == COUNT) & CE & ~kick_ev & ~DISABLE & terminal;
  // pulse_q counts completed pulse cycles starting from 0 on FIRE entry.
  assign pulse_done = (pulse_q == PULSE_LAST);

  // State and datapath registers
  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      state_q    <= COUNT;
      cnt_q      <= '0;
      fire_cnt_q <= '0;
      wd_reset_q <= 1'b0;
      kick_d_q   <= 1'b0;
      pulse_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fire_cnt_q <= fire_cnt_d;
      wd_reset_q <= wd_reset_d;
      kick_d_q   <= KICK;      // keeps tracking in FIRE too
      pulse_q    <= pulse_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COUNT:   if (timeout)    state_d = FIRE;
      FIRE:    if (pulse_done) state_d = COUNT;
      default: state_d = COUNT;
    endcase
  end

  // Next values of the output/datapath registers
  always_comb begin
    cnt_d      = cnt_q;
    fire_cnt_d = fire_cnt_q;
    pulse_d    = '0;
    wd_reset_d = (state_d == FIRE);
    unique case (state_q)
      COUNT: begin
        if (kick_ev || DISABLE) begin
          cnt_d = '0;
        end else if (CE) begin
          if (terminal) begin
            cnt_d = '0;
            if (fire_cnt_q != 4'hF) fire_cnt_d = fire_cnt_q + 4'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      FIRE: begin
        cnt_d   = '0;
        pulse_d = pulse_done ? 8'd0 : pulse_q + 8'd1;
      end
      default: cnt_d = '0;
    endcase
  end

  assign WD_RESET = wd_reset_q;
  assign WD_CNT   = cnt_q;
  assign FIRE_CNT = fire_cnt_q;

endmodule

// File: tb/tb_watchdog_ctrl.sv
// tb_watchdog_ctrl: scoreboard bench for watchdog_ctrl (CNT_WIDTH=4, PULSE_LEN=3).
// A behavioural model updated on each rising edge pushes the expected outputs;
// a monitor on the falling edge pops and compares against the DUT.
module tb_watchdog_ctrl;
  localparam int unsigned CW   = 4;
  localparam int unsigned PL   = 3;
  localparam int          MAXV = (1 << CW) - 1;

  logic          CK      = 1'b0;
  logic          RESET   = 1'b1;
  logic          CE      = 1'b0;
  logic          KICK    = 1'b0;
  logic          DISABLE = 1'b0;
  logic          WD_RESET;
  logic [CW-1:0] WD_CNT;
  logic [3:0]    FIRE_CNT;

  watchdog_ctrl #(
    .CNT_WIDTH(CW),
    .PULSE_LEN(PL)
  ) dut (
    .CK      (CK),
    .RESET   (RESET),
    .CE      (CE),
    .KICK    (KICK),
    .DISABLE (DISABLE),
    .WD_RESET(WD_RESET),
    .WD_CNT  (WD_CNT),
    .FIRE_CNT(FIRE_CNT)
  );

  always #5 CK = ~CK;

  typedef struct {
    int wd;
    int cnt;
    int fc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: counter value, remaining reset-pulse cycles, timeouts, last KICK level
  int m_cnt   = 0;
  int m_left  = 0;
  int m_fc    = 0;
  bit m_kprev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CK) begin
    exp_t e;
    bit   ev;
    if (RESET) begin
      m_cnt   = 0;
      m_left  = 0;
      m_fc    = 0;
      m_kprev = 1'b0;
    end else begin
      ev      = KICK && !m_kprev;
      m_kprev = KICK;
      if (m_left > 0) begin
        m_left--;
      end else if (ev || DISABLE) begin
        m_cnt = 0;
      end else if (CE) begin
        if (m_cnt == MAXV) begin
          m_left = PL;
          m_cnt  = 0;
          if (m_fc < 15) m_fc++;
        end else begin
          m_cnt++;
        end
      end
    end
    e.wd  = (m_left > 0) ? 1 : 0;
    e.cnt = m_cnt;
    e.fc  = m_fc;
    sb.push_back(e);
  end

  always @(negedge CK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("wd_reset", int'(WD_RESET), e.wd);
      check("wd_cnt",   int'(WD_CNT),   e.cnt);
      check("fire_cnt", int'(FIRE_CNT), e.fc);
    end
  end

  task automatic cyc(input logic ce, input logic k, input logic d);
    CE      = ce;
    KICK    = k;
    DISABLE = d;
    @(posedge CK);
    #1;
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL sim_timeout: got running expected finished at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic r, k, d;
    k = 1'b0;
    repeat (2) @(posedge CK);
    #1 RESET = 1'b0;

    // 16 isolated CE ticks -> timeout and a 3-cycle pulse
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    repeat (4) cyc(0, 0, 0);

    // 10 ticks, kick, 15 ticks -> counter at 15, no pulse
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end

    // Kick coinciding with terminal tick wins; KICK then held high for 16 ticks fires
    cyc(1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0);
      cyc(0, 1, 0);
    end
    repeat (4) cyc(0, 1, 0);

    // DISABLE with 40 ticks, then timeout with DISABLE and kicks during the pulse
    cyc(0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 1);
      cyc(0, 0, 1);
    end
    for (int i = 0; i < 16; i++) cyc(1, 0, 0);
    cyc(1, 1, 1);
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    repeat (2) cyc(0, 0, 0);

    // Continuous CE: 17+ consecutive timeouts, FIRE_CNT saturates
    repeat (17 * (16 + PL) + 5) cyc(1, 0, 0);

    // Asynchronous reset between edges in the middle of a pulse
    cyc(0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    @(negedge CK);
    #1;
    check("pre_reset_wd", int'(WD_RESET), 1);
    #1 RESET = 1'b1;
    #1;
    check("async_wd",  int'(WD_RESET), 0);
    check("async_cnt", int'(WD_CNT),   0);
    check("async_fc",  int'(FIRE_CNT), 0);
    @(posedge CK);
    #1;
    // KICK high on the first edge after release counts as a kick
    KICK  = 1'b1;
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0);
      cyc(0, 1, 0);
    end
    cyc(0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) k = ~k;
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 99) < 2);
      cyc(r, k, d);
    end

    repeat (2) cyc(0, 0, 0);
    @(negedge CK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
